// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared sequencer state encoding, default grid size and cell indexing
package gol_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } seq_state_t;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  function automatic int cell_idx(input int x, input int y, input int cols);
    return y * cols + x;
  endfunction

endpackage

// File: rtl/gol_cursor.sv
// rtl/gol_cursor.sv - wrap-around cursor x/y counters, moves honoured only while enabled
module gol_cursor
  import gol_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    left,
  input  logic                    right,
  input  logic                    up,
  input  logic                    down,
  output logic [$clog2(COLS)-1:0] x,
  output logic [$clog2(ROWS)-1:0] y
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Opposing moves on the same axis cancel because each branch requires the other to be low.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en) begin
      if (left && !right)
        x_d = (x_q == '0) ? XW'(COLS - 1) : x_q - XW'(1);
      else if (right && !left)
        x_d = (x_q == XW'(COLS - 1)) ? '0 : x_q + XW'(1);
      if (up && !down)
        y_d = (y_q == '0) ? YW'(ROWS - 1) : y_q - YW'(1);
      else if (down && !up)
        y_d = (y_q == YW'(ROWS - 1)) ? '0 : y_q + YW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/gol_sequencer.sv
// rtl/gol_sequencer.sv - run/pause/step sequencer owning the grid; optional GOL_STILL_LIFE_DETECT_EN adds stable
module gol_sequencer
  import gol_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int GEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    btn_run,
  input  logic                    btn_step,
  input  logic                    btn_clear,
  input  logic                    btn_toggle,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic [ROWS*COLS-1:0]    grid_next,
  output logic [ROWS*COLS-1:0]    grid,
  output logic [$clog2(COLS)-1:0] cursor_x,
  output logic [$clog2(ROWS)-1:0] cursor_y,
  output logic                    paused,
  output logic [GEN_W-1:0]        generation,
  output logic                    update
`ifdef GOL_STILL_LIFE_DETECT_EN
  ,
  output logic                    stable
`endif
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);

  seq_state_t       state_q, state_d;
  seq_state_t       ret_q, ret_d;
  logic [N-1:0]     grid_q, grid_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             update_q, update_d;
  logic             stable_q, stable_d;
  logic [IW-1:0]    tog_idx;
  logic             edit_en;

  // Editing is lowest priority: any higher-priority button in the same cycle suppresses it.
  assign edit_en = (state_q == PAUSED) && !btn_clear && !btn_run && !btn_step;
  assign tog_idx = IW'(cell_idx(int'(cursor_x), int'(cursor_y), COLS));

  gol_cursor #(.ROWS(ROWS), .COLS(COLS)) u_cursor (
    .clk   (clk),
    .rst   (rst),
    .en    (edit_en),
    .left  (btn_left),
    .right (btn_right),
    .up    (btn_up),
    .down  (btn_down),
    .x     (cursor_x),
    .y     (cursor_y)
  );

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    grid_d   = grid_q;
    gen_d    = gen_q;
    update_d = 1'b0;
    stable_d = 1'b0;
    if (btn_clear) begin
      grid_d  = '0;
      gen_d   = '0;
      state_d = PAUSED;
    end else begin
      case (state_q)
        PAUSED: begin
          if (btn_run) begin
            state_d = RUN;
          end else if (btn_step) begin
            state_d = COMMIT;
            ret_d   = PAUSED;
          end else if (btn_toggle) begin
            grid_d[tog_idx] = ~grid_q[tog_idx];
          end
        end
        RUN: begin
          if (btn_run) begin
            state_d = PAUSED;
          end else if (tick) begin
            state_d = COMMIT;
            ret_d   = RUN;
          end
        end
        COMMIT: begin
          state_d = ret_q;
`ifdef GOL_STILL_LIFE_DETECT_EN
          if (grid_next == grid_q) begin
            state_d  = PAUSED;
            stable_d = 1'b1;
          end else
`endif
          begin
            grid_d   = grid_next;
            update_d = 1'b1;
            if (gen_q != '1)
              gen_d = gen_q + GEN_W'(1);
          end
        end
        default: state_d = PAUSED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PAUSED;
      ret_q    <= PAUSED;
      grid_q   <= '0;
      gen_q    <= '0;
      update_q <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      grid_q   <= grid_d;
      gen_q    <= gen_d;
      update_q <= update_d;
      stable_q <= stable_d;
    end
  end

  assign grid       = grid_q;
  assign generation = gen_q;
  assign update     = update_q;
  assign paused     = (state_q == PAUSED);
`ifdef GOL_STILL_LIFE_DETECT_EN
  assign stable     = stable_q;
`else
  logic unused_stable;
  assign unused_stable = stable_q;
`endif

endmodule

// File: doc/gol_sequencer.md
Name: gol_sequencer

Overview:
- Sequences the Game of Life evolve datapath and owns the registered grid.
- Decides when the combinational next-generation grid is committed: on a rate tick while running, or on a single-step request while paused.
- Handles editing while paused: cursor moves, cell toggles, clear.
- Sits between the debounced button controls, the rate divider (`tick`) and the evolve datapath.

Parameters:
- ROWS, 8, grid height in cells
- COLS, 8, grid width in cells
- GEN_W, 16, generation counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- tick  in  1  one-cycle generation-rate strobe from the divider
- btn_run  in  1  one-cycle pulse; toggles run/pause
- btn_step  in  1  one-cycle pulse; one generation, honoured only when paused
- btn_clear  in  1  one-cycle pulse; clears grid and generation
- btn_toggle  in  1  one-cycle pulse; inverts cell at cursor, honoured only when paused
- btn_left, btn_right, btn_up, btn_down  in  1 each  one-cycle cursor move pulses
- grid_next  in  ROWS*COLS  next generation from the evolve datapath (combinational from `grid`)
- grid  out  ROWS*COLS  current grid; bit index = y*COLS + x
- cursor_x  out  $clog2(COLS)  selected column
- cursor_y  out  $clog2(ROWS)  selected row
- paused  out  1  high in PAUSED
- generation  out  GEN_W  generations committed since reset or clear
- update  out  1  one-cycle pulse in the cycle after each commit

Behaviour:
- Reset (async, `rst`=1):
  - grid=0, cursor=(0,0), generation=0, update=0.
  - State PAUSED, so paused=1.
  - Outputs are held while `rst` is high.
  - Reset mid-COMMIT discards the pending commit.
- States:
  - PAUSED → RUN on btn_run.
  - PAUSED → COMMIT on btn_step; return state recorded as PAUSED.
  - RUN → PAUSED on btn_run.
  - RUN → COMMIT on tick; return state recorded as RUN.
  - COMMIT → return state, unconditionally after one cycle.
- Commit timing: at the edge leaving COMMIT:
  - grid <= grid_next;
  - generation <= generation+1, saturating at all-ones;
  - update <= 1 for exactly one cycle.
  - Latency: tick/step sampled at edge n gives a new grid visible after edge n+1.
- Input priority, same cycle: btn_clear > btn_run > btn_step/tick > btn_toggle > cursor moves.
- btn_clear:
  - Accepted in any state, including COMMIT; aborts the commit.
  - grid=0, generation=0, update=0, next state PAUSED. Cursor is unchanged.
- Buttons during COMMIT:
  - All except btn_clear are ignored, with no queuing.
  - tick arriving in COMMIT is dropped.
- In RUN:
  - btn_step, btn_toggle and cursor moves are ignored.
  - A tick in the same cycle as btn_run pauses without committing.
- Editing in PAUSED:
  - btn_toggle inverts grid[cursor_y*COLS+cursor_x] at the next edge.
  - Cursor moves wrap: left at x=0 → COLS-1; right at COLS-1 → 0; up at y=0 → ROWS-1; down at ROWS-1 → 0.
  - Opposing simultaneous moves (left+right, up+down) cancel on that axis.
  - Toggle together with a move applies to the pre-move cursor.
- Editing does not change generation.

Optional Feature:
- Macro: GOL_STILL_LIFE_DETECT_EN.
- Defined:
  - Adds output port `stable` (1 bit).
  - In COMMIT, if grid_next == grid: no write, no generation increment, update stays 0, next state is PAUSED, and stable pulses 1 for one cycle.
  - A step on a still grid behaves the same way.
- Undefined: port absent; every commit writes and increments regardless of content.

Decomposition:
- Package gol_pkg:
  - seq_state_t enum {PAUSED, RUN, COMMIT};
  - default ROWS/COLS constants;
  - cell_idx(x,y) function.
- Sub-module gol_cursor:
  - wrap-around x/y counters with move inputs and enable;
  - enable is driven high only in PAUSED.

Test Plan:
1. Reset then idle 5 cycles → paused=1, grid=0, cursor=(0,0), generation=0, update never high.
2. Paused at (0,0):
   - btn_left, then btn_up → cursor=(7,7).
   - btn_toggle → grid bit 63 = 1.
   - btn_toggle again → bit 63 = 0.
3. Blinker (bits 9,10,11), paused, btn_step:
   - grid = bits 2,10,18 two edges later; generation=1; one update pulse; paused=1 after.
4. btn_run, then 4 ticks spaced 10 cycles:
   - generation=4, 4 update pulses, blinker phase back to 9,10,11.
   - Then btn_run and tick in the same cycle → paused=1, generation stays 4.
5. btn_clear asserted in the COMMIT cycle → grid=0, generation=0, no update pulse, paused=1, cursor retained.
6. With GOL_STILL_LIFE_DETECT_EN, 2x2 block, running, tick:
   - stable pulses once, paused=1, generation unchanged, grid unchanged.
